// File: rtl/axi4_lite_arbiter_2to1_pkg.sv
// Shared definitions for the 2:1 AXI4-Lite arbiter: FSM encodings, response codes, default widths.
package axi4_lite_arbiter_2to1_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

endpackage

// File: rtl/axi4_lite_arbiter_2to1_rr_arbiter2.sv
// Two-requester round-robin pick: on a tie the requester that was not served last wins.
module axi4_lite_arbiter_2to1_rr_arbiter2 (
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi4_lite_arbiter_2to1.sv
// Shares one AXI4-Lite slave between two masters; read and write paths arbitrate independently.
//   state  | meaning
//   *_IDLE | no grant, arbitrating among valid requests
//   W_ADDR | forwarding AW/W of granted master until both handshakes done
//   W_RESP | routing B back to granted master
//   R_ADDR | forwarding AR of granted master
//   R_DATA | routing R back to granted master
module axi4_lite_arbiter_2to1
  import axi4_lite_arbiter_2to1_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [2*ADDR_W-1:0]   m_awaddr_in,
  input  logic [5:0]            m_awprot_in,
  input  logic [1:0]            m_awvalid_in,
  output logic [1:0]            m_awready_out,
  input  logic [2*DATA_W-1:0]   m_wdata_in,
  input  logic [2*STRB_W-1:0]   m_wstrb_in,
  input  logic [1:0]            m_wvalid_in,
  output logic [1:0]            m_wready_out,
  output logic [3:0]            m_bresp_out,
  output logic [1:0]            m_bvalid_out,
  input  logic [1:0]            m_bready_in,
  input  logic [2*ADDR_W-1:0]   m_araddr_in,
  input  logic [5:0]            m_arprot_in,
  input  logic [1:0]            m_arvalid_in,
  output logic [1:0]            m_arready_out,
  output logic [2*DATA_W-1:0]   m_rdata_out,
  output logic [3:0]            m_rresp_out,
  output logic [1:0]            m_rvalid_out,
  input  logic [1:0]            m_rready_in,
  output logic [ADDR_W-1:0]     s_awaddr_out,
  output logic [2:0]            s_awprot_out,
  output logic                  s_awvalid_out,
  input  logic                  s_awready_in,
  output logic [DATA_W-1:0]     s_wdata_out,
  output logic [STRB_W-1:0]     s_wstrb_out,
  output logic                  s_wvalid_out,
  input  logic                  s_wready_in,
  input  logic [1:0]            s_bresp_in,
  input  logic                  s_bvalid_in,
  output logic                  s_bready_out,
  output logic [ADDR_W-1:0]     s_araddr_out,
  output logic [2:0]            s_arprot_out,
  output logic                  s_arvalid_out,
  input  logic                  s_arready_in,
  input  logic [DATA_W-1:0]     s_rdata_in,
  input  logic [1:0]            s_rresp_in,
  input  logic                  s_rvalid_in,
  output logic                  s_rready_out,
  output logic [1:0]            wr_grant_out,
  output logic [1:0]            rd_grant_out
);

  wr_state_t  r_wr_state, w_wr_state_nxt;
  rd_state_t  r_rd_state, w_rd_state_nxt;
  logic [1:0] r_wr_grant, r_rd_grant, w_wr_arb, w_rd_arb;
  logic       r_wr_last, r_rd_last, r_aw_done, r_w_done;
  logic       w_wr_g, w_rd_g, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  assign w_wr_g = r_wr_grant[1];
  assign w_rd_g = r_rd_grant[1];
  assign wr_grant_out = r_wr_grant;
  assign rd_grant_out = r_rd_grant;

  axi4_lite_arbiter_2to1_rr_arbiter2 u_wr_arb (
    .i_req(m_awvalid_in), .i_last(r_wr_last), .o_grant(w_wr_arb));
  axi4_lite_arbiter_2to1_rr_arbiter2 u_rd_arb (
    .i_req(m_arvalid_in), .i_last(r_rd_last), .o_grant(w_rd_arb));

  // Payloads are muxed from the current grant; responses are broadcast and qualified by valid.
  assign s_awaddr_out = w_wr_g ? m_awaddr_in[2*ADDR_W-1:ADDR_W] : m_awaddr_in[ADDR_W-1:0];
  assign s_awprot_out = w_wr_g ? m_awprot_in[5:3] : m_awprot_in[2:0];
  assign s_wdata_out  = w_wr_g ? m_wdata_in[2*DATA_W-1:DATA_W] : m_wdata_in[DATA_W-1:0];
  assign s_wstrb_out  = w_wr_g ? m_wstrb_in[2*STRB_W-1:STRB_W] : m_wstrb_in[STRB_W-1:0];
  assign s_araddr_out = w_rd_g ? m_araddr_in[2*ADDR_W-1:ADDR_W] : m_araddr_in[ADDR_W-1:0];
  assign s_arprot_out = w_rd_g ? m_arprot_in[5:3] : m_arprot_in[2:0];
  assign m_bresp_out  = {2{s_bresp_in}};
  assign m_rdata_out  = {2{s_rdata_in}};
  assign m_rresp_out  = {2{s_rresp_in}};

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    m_awready_out  = 2'b00;
    m_wready_out   = 2'b00;
    m_bvalid_out   = 2'b00;
    s_awvalid_out  = 1'b0;
    s_wvalid_out   = 1'b0;
    s_bready_out   = 1'b0;
    w_aw_hs        = 1'b0;
    w_w_hs         = 1'b0;
    w_b_hs         = 1'b0;
    case (r_wr_state)
      W_IDLE: if (|w_wr_arb) w_wr_state_nxt = W_ADDR;
      W_ADDR: begin
        // A completed channel is masked so a still-valid master cannot handshake twice.
        s_awvalid_out         = m_awvalid_in[w_wr_g] & ~r_aw_done;
        s_wvalid_out          = m_wvalid_in[w_wr_g] & ~r_w_done;
        m_awready_out[w_wr_g] = s_awready_in & ~r_aw_done;
        m_wready_out[w_wr_g]  = s_wready_in & ~r_w_done;
        w_aw_hs               = s_awvalid_out & s_awready_in;
        w_w_hs                = s_wvalid_out & s_wready_in;
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) w_wr_state_nxt = W_RESP;
      end
      W_RESP: begin
        m_bvalid_out[w_wr_g] = s_bvalid_in;
        s_bready_out         = m_bready_in[w_wr_g];
        w_b_hs               = s_bvalid_in & m_bready_in[w_wr_g];
        if (w_b_hs) w_wr_state_nxt = W_IDLE;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    m_arready_out  = 2'b00;
    m_rvalid_out   = 2'b00;
    s_arvalid_out  = 1'b0;
    s_rready_out   = 1'b0;
    w_ar_hs        = 1'b0;
    w_r_hs         = 1'b0;
    case (r_rd_state)
      R_IDLE: if (|w_rd_arb) w_rd_state_nxt = R_ADDR;
      R_ADDR: begin
        s_arvalid_out         = m_arvalid_in[w_rd_g];
        m_arready_out[w_rd_g] = s_arready_in;
        w_ar_hs               = s_arvalid_out & s_arready_in;
        if (w_ar_hs) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        m_rvalid_out[w_rd_g] = s_rvalid_in;
        s_rready_out         = m_rready_in[w_rd_g];
        w_r_hs               = s_rvalid_in & m_rready_in[w_rd_g];
        if (w_r_hs) w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_state <= W_IDLE;
      r_wr_grant <= 2'b00;
      r_wr_last  <= 1'b1;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rd_state <= R_IDLE;
      r_rd_grant <= 2'b00;
      r_rd_last  <= 1'b1;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_rd_state <= w_rd_state_nxt;
      case (r_wr_state)
        W_IDLE: if (|w_wr_arb) r_wr_grant <= w_wr_arb;
        W_ADDR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
        end
        W_RESP: if (w_b_hs) begin
          r_wr_last  <= w_wr_g;
          r_wr_grant <= 2'b00;
          r_aw_done  <= 1'b0;
          r_w_done   <= 1'b0;
        end
        default: ;
      endcase
      case (r_rd_state)
        R_IDLE: if (|w_rd_arb) r_rd_grant <= w_rd_arb;
        R_DATA: if (w_r_hs) begin
          r_rd_last  <= w_rd_g;
          r_rd_grant <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_arbiter_2to1.sv
// Directed bench for the 2:1 AXI4-Lite arbiter; expected values are hand-derived per step.
module tb_axi4_lite_arbiter_2to1;
  import axi4_lite_arbiter_2to1_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [2*AW-1:0] m_awaddr_in, m_araddr_in;
  logic [5:0]      m_awprot_in, m_arprot_in;
  logic [1:0]      m_awvalid_in, m_awready_out, m_wvalid_in, m_wready_out;
  logic [2*DW-1:0] m_wdata_in, m_rdata_out;
  logic [2*SW-1:0] m_wstrb_in;
  logic [3:0]      m_bresp_out, m_rresp_out;
  logic [1:0]      m_bvalid_out, m_bready_in, m_arvalid_in, m_arready_out;
  logic [1:0]      m_rvalid_out, m_rready_in;
  logic [AW-1:0]   s_awaddr_out, s_araddr_out;
  logic [2:0]      s_awprot_out, s_arprot_out;
  logic            s_awvalid_out, s_awready_in, s_wvalid_out, s_wready_in;
  logic [DW-1:0]   s_wdata_out, s_rdata_in;
  logic [SW-1:0]   s_wstrb_out;
  logic [1:0]      s_bresp_in, s_rresp_in;
  logic            s_bvalid_in, s_bready_out, s_arvalid_out, s_arready_in;
  logic            s_rvalid_in, s_rready_out;
  logic [1:0]      wr_grant_out, rd_grant_out;

  int n_pass  = 0;
  int n_total = 0;

  axi4_lite_arbiter_2to1 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_awaddr_in(m_awaddr_in), .m_awprot_in(m_awprot_in), .m_awvalid_in(m_awvalid_in),
    .m_awready_out(m_awready_out), .m_wdata_in(m_wdata_in), .m_wstrb_in(m_wstrb_in),
    .m_wvalid_in(m_wvalid_in), .m_wready_out(m_wready_out), .m_bresp_out(m_bresp_out),
    .m_bvalid_out(m_bvalid_out), .m_bready_in(m_bready_in), .m_araddr_in(m_araddr_in),
    .m_arprot_in(m_arprot_in), .m_arvalid_in(m_arvalid_in), .m_arready_out(m_arready_out),
    .m_rdata_out(m_rdata_out), .m_rresp_out(m_rresp_out), .m_rvalid_out(m_rvalid_out),
    .m_rready_in(m_rready_in), .s_awaddr_out(s_awaddr_out), .s_awprot_out(s_awprot_out),
    .s_awvalid_out(s_awvalid_out), .s_awready_in(s_awready_in), .s_wdata_out(s_wdata_out),
    .s_wstrb_out(s_wstrb_out), .s_wvalid_out(s_wvalid_out), .s_wready_in(s_wready_in),
    .s_bresp_in(s_bresp_in), .s_bvalid_in(s_bvalid_in), .s_bready_out(s_bready_out),
    .s_araddr_out(s_araddr_out), .s_arprot_out(s_arprot_out), .s_arvalid_out(s_arvalid_out),
    .s_arready_in(s_arready_in), .s_rdata_in(s_rdata_in), .s_rresp_in(s_rresp_in),
    .s_rvalid_in(s_rvalid_in), .s_rready_out(s_rready_out),
    .wr_grant_out(wr_grant_out), .rd_grant_out(rd_grant_out)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    m_awaddr_in = '0; m_awprot_in = '0; m_awvalid_in = '0;
    m_wdata_in = '0; m_wstrb_in = '0; m_wvalid_in = '0; m_bready_in = '0;
    m_araddr_in = '0; m_arprot_in = '0; m_arvalid_in = '0; m_rready_in = '0;
    s_awready_in = 1'b0; s_wready_in = 1'b0; s_bresp_in = '0; s_bvalid_in = 1'b0;
    s_arready_in = 1'b0; s_rdata_in = '0; s_rresp_in = '0; s_rvalid_in = 1'b0;
  endtask

  initial begin
    clear_inputs();
    aresetn = 1'b0;
    cyc(); cyc();
    chk("rst_wr_grant", wr_grant_out, 2'b00);
    chk("rst_rd_grant", rd_grant_out, 2'b00);
    chk("rst_s_awvalid", s_awvalid_out, 1'b0);
    chk("rst_s_arvalid", s_arvalid_out, 1'b0);
    aresetn = 1'b1;

    // Single m0 write, slave ready immediately
    m_awaddr_in = {32'h0, 32'd16}; m_awvalid_in = 2'b01;
    m_wdata_in = {32'h0, 32'hF0B4A596}; m_wstrb_in = {4'h0, 4'b1011}; m_wvalid_in = 2'b01;
    s_awready_in = 1'b1; s_wready_in = 1'b1; m_bready_in = 2'b01;
    #1;
    chk("t1_grant_before_arb", wr_grant_out, 2'b00);
    cyc();
    chk("t1_grant", wr_grant_out, 2'b01);
    chk("t1_s_awaddr", s_awaddr_out, 32'd16);
    chk("t1_s_wdata", s_wdata_out, 32'hF0B4A596);
    chk("t1_s_wstrb", s_wstrb_out, 4'b1011);
    chk("t1_m_awready", m_awready_out, 2'b01);
    chk("t1_m_wready", m_wready_out, 2'b01);
    chk("t1_s_awvalid", s_awvalid_out, 1'b1);
    cyc();
    m_awvalid_in = 2'b00; m_wvalid_in = 2'b00; s_bvalid_in = 1'b1; s_bresp_in = RESP_OKAY;
    #1;
    chk("t1_m_bvalid", m_bvalid_out, 2'b01);
    chk("t1_m_bresp", m_bresp_out[1:0], 2'b00);
    chk("t1_s_bready", s_bready_out, 1'b1);
    chk("t1_s_awvalid_resp", s_awvalid_out, 1'b0);
    cyc();
    chk("t1_grant_idle", wr_grant_out, 2'b00);
    chk("t1_m_bvalid_idle", m_bvalid_out, 2'b00);
    chk("t1_s_bready_idle", s_bready_out, 1'b0);
    clear_inputs();

    // Simultaneous write requests after reset: m0 first, then m1
    aresetn = 1'b0; cyc(); aresetn = 1'b1;
    m_awaddr_in = {32'h200, 32'h100}; m_awvalid_in = 2'b11;
    m_wdata_in = {32'hBBBB0002, 32'hAAAA0001}; m_wstrb_in = 8'hFF; m_wvalid_in = 2'b11;
    s_awready_in = 1'b1; s_wready_in = 1'b1;
    s_bvalid_in = 1'b1; s_bresp_in = RESP_SLVERR; m_bready_in = 2'b11;
    #1;
    chk("t2_grant0", wr_grant_out, 2'b00);
    chk("t2_bvalid_idle", m_bvalid_out, 2'b00);
    cyc();
    chk("t2_grant1", wr_grant_out, 2'b01);
    chk("t2_s_awaddr_m0", s_awaddr_out, 32'h100);
    chk("t2_m_awready_m0", m_awready_out, 2'b01);
    cyc();
    m_awvalid_in = 2'b10; m_wvalid_in = 2'b10;
    #1;
    chk("t2_grant2", wr_grant_out, 2'b01);
    chk("t2_m_bvalid_m0", m_bvalid_out, 2'b01);
    chk("t2_m_bresp_m0", m_bresp_out[1:0], 2'b10);
    cyc();
    chk("t2_grant3", wr_grant_out, 2'b00);
    chk("t2_bvalid_gap", m_bvalid_out, 2'b00);
    cyc();
    chk("t2_grant4", wr_grant_out, 2'b10);
    chk("t2_s_awaddr_m1", s_awaddr_out, 32'h200);
    chk("t2_s_wdata_m1", s_wdata_out, 32'hBBBB0002);
    chk("t2_m_awready_m1", m_awready_out, 2'b10);
    cyc();
    m_awvalid_in = 2'b00; m_wvalid_in = 2'b00;
    #1;
    chk("t2_m_bvalid_m1", m_bvalid_out, 2'b10);
    chk("t2_m_bresp_m1", m_bresp_out[3:2], 2'b10);
    cyc();
    chk("t2_grant_end", wr_grant_out, 2'b00);
    clear_inputs();

    // m1 read concurrent with m0 write
    m_awaddr_in = {32'h0, 32'h40}; m_awvalid_in = 2'b01;
    m_wdata_in = {32'h0, 32'h12345678}; m_wstrb_in = {4'h0, 4'hF}; m_wvalid_in = 2'b01;
    m_araddr_in = {32'd16, 32'h0}; m_arprot_in = {3'b010, 3'b000}; m_arvalid_in = 2'b10;
    s_awready_in = 1'b1; s_wready_in = 1'b1; s_arready_in = 1'b1;
    cyc();
    chk("t3_wr_grant", wr_grant_out, 2'b01);
    chk("t3_rd_grant", rd_grant_out, 2'b10);
    chk("t3_s_araddr", s_araddr_out, 32'd16);
    chk("t3_s_arprot", s_arprot_out, 3'b010);
    chk("t3_m_arready", m_arready_out, 2'b10);
    chk("t3_s_arvalid", s_arvalid_out, 1'b1);
    cyc();
    m_awvalid_in = 2'b00; m_wvalid_in = 2'b00; m_arvalid_in = 2'b00;
    s_rvalid_in = 1'b1; s_rdata_in = 32'hF0B4A596; s_rresp_in = RESP_OKAY; m_rready_in = 2'b10;
    s_bvalid_in = 1'b1; s_bresp_in = RESP_OKAY; m_bready_in = 2'b01;
    #1;
    chk("t3_m_rvalid", m_rvalid_out, 2'b10);
    chk("t3_m_rdata", m_rdata_out[63:32], 32'hF0B4A596);
    chk("t3_m_rresp", m_rresp_out[3:2], 2'b00);
    chk("t3_s_rready", s_rready_out, 1'b1);
    chk("t3_m_bvalid", m_bvalid_out, 2'b01);
    chk("t3_wr_grant_resp", wr_grant_out, 2'b01);
    chk("t3_rd_grant_data", rd_grant_out, 2'b10);
    cyc();
    chk("t3_wr_grant_end", wr_grant_out, 2'b00);
    chk("t3_rd_grant_end", rd_grant_out, 2'b00);
    clear_inputs();

    // W handshake three cycles ahead of AW
    m_awaddr_in = {32'h0, 32'h80}; m_awvalid_in = 2'b01;
    m_wdata_in = {32'h0, 32'h55AA55AA}; m_wstrb_in = {4'h0, 4'hF}; m_wvalid_in = 2'b01;
    s_wready_in = 1'b1; s_awready_in = 1'b0; s_bvalid_in = 1'b1; m_bready_in = 2'b00;
    cyc();
    chk("t4_s_wvalid", s_wvalid_out, 1'b1);
    chk("t4_s_awvalid", s_awvalid_out, 1'b1);
    chk("t4_m_wready", m_wready_out, 2'b01);
    chk("t4_m_awready", m_awready_out, 2'b00);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_s_wvalid_done", s_wvalid_out, 1'b0);
      chk("t4_m_wready_done", m_wready_out, 2'b00);
      chk("t4_s_awvalid_wait", s_awvalid_out, 1'b1);
      chk("t4_no_early_resp", m_bvalid_out, 2'b00);
    end
    s_awready_in = 1'b1;
    #1;
    chk("t4_m_awready_late", m_awready_out, 2'b01);
    cyc();
    m_awvalid_in = 2'b00; m_wvalid_in = 2'b00;
    #1;
    chk("t4_m_bvalid", m_bvalid_out, 2'b01);
    chk("t4_s_awvalid_resp", s_awvalid_out, 1'b0);
    m_bready_in = 2'b01;
    #1;
    chk("t4_s_bready", s_bready_out, 1'b1);
    cyc();
    chk("t4_grant_end", wr_grant_out, 2'b00);
    clear_inputs();

    // Read data stalled by master; m1 waits, then wins the following tie
    m_araddr_in = {32'h300, 32'h30}; m_arvalid_in = 2'b11; s_arready_in = 1'b1;
    cyc();
    chk("t5_rd_grant_m0", rd_grant_out, 2'b01);
    chk("t5_s_araddr_m0", s_araddr_out, 32'h30);
    cyc();
    m_arvalid_in = 2'b10; s_rvalid_in = 1'b1; s_rdata_in = 32'hCAFE0001; m_rready_in = 2'b00;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_rd_grant_hold", rd_grant_out, 2'b01);
      chk("t5_s_rready_low", s_rready_out, 1'b0);
      chk("t5_m_rvalid", m_rvalid_out, 2'b01);
      chk("t5_m1_blocked", m_arready_out, 2'b00);
      chk("t5_s_arvalid_off", s_arvalid_out, 1'b0);
      cyc();
    end
    m_rready_in = 2'b01;
    #1;
    chk("t5_s_rready_high", s_rready_out, 1'b1);
    chk("t5_m_rdata", m_rdata_out[31:0], 32'hCAFE0001);
    m_araddr_in = {32'h300, 32'h34}; m_arvalid_in = 2'b11;
    cyc();
    s_rvalid_in = 1'b0; m_rready_in = 2'b00;
    #1;
    chk("t5_rd_grant_gap", rd_grant_out, 2'b00);
    cyc();
    chk("t5_rd_grant_m1", rd_grant_out, 2'b10);
    chk("t5_s_araddr_m1", s_araddr_out, 32'h300);
    cyc();
    m_arvalid_in = 2'b01; s_rvalid_in = 1'b1; m_rready_in = 2'b10;
    #1;
    chk("t5_m_rvalid_m1", m_rvalid_out, 2'b10);
    cyc();
    chk("t5_rd_grant_end", rd_grant_out, 2'b00);
    clear_inputs();
    cyc();

    // Reset while in W_RESP; m1 served normally afterwards
    m_awaddr_in = {32'h0, 32'h90}; m_awvalid_in = 2'b01; m_wvalid_in = 2'b01;
    s_awready_in = 1'b1; s_wready_in = 1'b1;
    cyc();
    cyc();
    m_awvalid_in = 2'b00; m_wvalid_in = 2'b00;
    aresetn = 1'b0; s_bvalid_in = 1'b1; m_bready_in = 2'b01;
    #1;
    chk("t6_bvalid_pre_rst", m_bvalid_out, 2'b01);
    cyc();
    chk("t6_wr_grant_rst", wr_grant_out, 2'b00);
    chk("t6_m_bvalid_rst", m_bvalid_out, 2'b00);
    chk("t6_s_bready_rst", s_bready_out, 1'b0);
    chk("t6_s_awvalid_rst", s_awvalid_out, 1'b0);
    chk("t6_rd_grant_rst", rd_grant_out, 2'b00);
    aresetn = 1'b1; s_bvalid_in = 1'b0; m_bready_in = 2'b00;
    m_awaddr_in = {32'h500, 32'h0}; m_awvalid_in = 2'b10; m_wvalid_in = 2'b10;
    cyc();
    chk("t6_wr_grant_m1", wr_grant_out, 2'b10);
    chk("t6_s_awaddr_m1", s_awaddr_out, 32'h500);
    cyc();
    m_awvalid_in = 2'b00; m_wvalid_in = 2'b00; s_bvalid_in = 1'b1; m_bready_in = 2'b10;
    #1;
    chk("t6_m_bvalid_m1", m_bvalid_out, 2'b10);
    cyc();
    chk("t6_wr_grant_end", wr_grant_out, 2'b00);
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axi4_lite_arbiter_2to1.md
Name: axi4_lite_arbiter_2to1

Overview:
Shares one AXI4-Lite slave (the axi4_lite_slave adaptor) between two AXI4-Lite masters, m0 and m1.
- Read and write paths are arbitrated independently, each by its own round-robin FSM.
- A grant is held until that transaction's response completes.
- Sits between the master-side interconnect and the slave adaptor.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (STRB_W = DATA_W/8)

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous active-low
m_awaddr_in  in  2*ADDR_W  master AW address, m1 in upper slice
m_awprot_in  in  6  master AW prot
m_awvalid_in  in  2  master AW valid
m_awready_out  out  2  master AW ready
m_wdata_in  in  2*DATA_W  master write data
m_wstrb_in  in  2*STRB_W  master write strobes
m_wvalid_in  in  2  master W valid
m_wready_out  out  2  master W ready
m_bresp_out  out  4  master B response
m_bvalid_out  out  2  master B valid
m_bready_in  in  2  master B ready
m_araddr_in  in  2*ADDR_W  master AR address
m_arprot_in  in  6  master AR prot
m_arvalid_in  in  2  master AR valid
m_arready_out  out  2  master AR ready
m_rdata_out  out  2*DATA_W  master read data
m_rresp_out  out  4  master R response
m_rvalid_out  out  2  master R valid
m_rready_in  in  2  master R ready
s_awaddr_out/s_awprot_out/s_awvalid_out  out  ADDR_W/3/1  slave AW
s_awready_in  in  1  slave AW ready
s_wdata_out/s_wstrb_out/s_wvalid_out  out  DATA_W/STRB_W/1  slave W
s_wready_in  in  1  slave W ready
s_bresp_in/s_bvalid_in  in  2/1  slave B
s_bready_out  out  1  slave B ready
s_araddr_out/s_arprot_out/s_arvalid_out  out  ADDR_W/3/1  slave AR
s_arready_in  in  1  slave AR ready
s_rdata_in/s_rresp_in/s_rvalid_in  in  DATA_W/2/1  slave R
s_rready_out  out  1  slave R ready
wr_grant_out  out  2  one-hot active write grant, 0 when idle
rd_grant_out  out  2  one-hot active read grant, 0 when idle

Behaviour:
Write FSM states: W_IDLE, W_ADDR, W_RESP.
- W_IDLE: write request = m_awvalid_in[i].
  - If only one master requests, grant it.
  - If both request, grant the master other than wr_last.
  - The grant is registered and the FSM moves to W_ADDR. One cycle of arbitration latency.
- W_ADDR: forward AW and W from granted master g to the slave; route s_awready_in and s_wready_in back to m*_ready_out[g] only.
  - Track aw_done and w_done. Each flag is set on its handshake; the two may complete in the same or different cycles.
  - Once a channel's handshake is done, drive its s_*valid_out to 0.
  - Move to W_RESP in the cycle where both handshakes are complete.
- W_RESP: m_bvalid_out[g] = s_bvalid_in, m_bresp_out[g] = s_bresp_in, s_bready_out = m_bready_in[g].
  - On s_bvalid_in & m_bready_in[g]: wr_last <= g, clear the flags, go to W_IDLE.
  - The next grant is therefore issued no earlier than the following cycle.
Read FSM states: R_IDLE, R_ADDR, R_DATA. Same arbitration rule using m_arvalid_in and rd_last.
- R_ADDR forwards AR until s_arready_in.
- R_DATA routes R to master g until s_rvalid_in & m_rready_in[g].
Non-granted master: all ready/valid outputs are 0. Slave-side valids and readies are 0 outside their forwarding states. Data and address outputs are muxed from g (don't-care when idle).
Read and write paths may be active concurrently, including for the same master.
Reset (aresetn=0 at a clock edge):
- Both FSMs go to IDLE, grants go to 0, flags are cleared.
- wr_last and rd_last go to 1, so m0 wins the first tie.
- All valid/ready outputs are 0 in the next cycle.
- A transaction aborted mid-flight is dropped, with no response.
A master that deasserts valid before its handshake is protocol-illegal; behaviour in that case is unspecified, and the FSM holds state.

Decomposition:
- Shared package: FSM state encodings, the AXI response constants OKAY=2'b00 and SLVERR=2'b10, and the AXI4-Lite default widths.
- Sub-module rr_arbiter2: 2-bit request in, last pointer, one-hot grant out. Instantiated once for write and once for read.

Test Plan:
1. m0 writes addr 16, data 32'hF0B4A596, strb 4'b1011, slave ready at once, bresp 00 -> wr_grant_out=01 one cycle after awvalid; m0 sees bvalid with bresp 00; FSM back to W_IDLE.
2. m0 and m1 raise awvalid in the same cycle -> m0 is served first, then m1; wr_grant_out sequence 01, 00, 10.
3. m1 reads addr 16, slave returns rdata 32'hF0B4A596 with rresp 00 while m0 writes -> both complete concurrently, with rd_grant_out=10 and wr_grant_out=01.
4. W handshake completes 3 cycles before AW -> s_wvalid_out drops after its handshake; FSM enters W_RESP only after the AW handshake.
5. m_rready_in held low for 4 cycles with s_rvalid_in high -> grant held and s_rready_out=0 until m_rready_in rises; m1 is blocked meanwhile.
6. aresetn low during W_RESP -> next cycle all valids/readies are 0 and grants are 0; a subsequent m1 request is granted normally.
